// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short press, long press and double click pulses.
// Optional auto-repeat while a long press is held: define BPC_AUTO_REPEAT_EN.
module button_press_classifier #(
    parameter int LONG_TICKS   = 100_000_000,
    parameter int DCLICK_TICKS = 30_000_000,
    parameter int REPEAT_TICKS = 20_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic p_edge,
    input  logic n_edge,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_tick,
    output logic busy
);

    localparam int MAX_LD = (LONG_TICKS > DCLICK_TICKS) ? LONG_TICKS : DCLICK_TICKS;
    localparam int MAX_T  = (MAX_LD > REPEAT_TICKS) ? MAX_LD : REPEAT_TICKS;
    localparam int CNT_W  = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_LONG,
        S_GAP,
        S_PRESS2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;
    logic             repeat_q, repeat_d;
    logic             busy_q, busy_d;
    logic             p_ev, n_ev;
    logic             cnt_clr, cnt_hold;

    // Simultaneous edges cancel each other; only a lone edge is an event.
    assign p_ev = p_edge & ~n_edge;
    assign n_ev = n_edge & ~p_edge;

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        dbl_d    = 1'b0;
        repeat_d = 1'b0;
        cnt_clr  = 1'b0;
        cnt_hold = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_hold = 1'b1;
                if (p_ev) state_d = S_PRESS;
            end
            S_PRESS: begin
                if (n_ev) begin
                    state_d = S_GAP;
                end else if (cnt_q == CNT_W'(LONG_TICKS - 1)) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                end
            end
            S_LONG: begin
                if (n_ev) begin
                    state_d = S_IDLE;
                end else begin
`ifdef BPC_AUTO_REPEAT_EN
                    if (cnt_q == CNT_W'(REPEAT_TICKS - 1)) begin
                        repeat_d = 1'b1;
                        cnt_clr  = 1'b1;
                    end
`else
                    cnt_hold = 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (p_ev) begin
                    state_d = S_PRESS2;
                end else if (cnt_q == CNT_W'(DCLICK_TICKS - 1)) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                end
            end
            S_PRESS2: begin
                if (n_ev) begin
                    state_d = S_IDLE;
                    dbl_d   = 1'b1;
                end else if (cnt_q == CNT_W'(LONG_TICKS - 1)) begin
                    state_d = S_LONG;
                    dbl_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d != state_q) || cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_hold) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            dbl_q    <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            dbl_q    <= dbl_d;
            repeat_q <= repeat_d;
            busy_q   <= busy_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign repeat_tick  = repeat_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: gesture table, reset corner case, randomized run vs timestamp model.
module tb_button_press_classifier;

    localparam int LT = 100;
    localparam int DT = 40;
    localparam int RT = 20;
`ifdef BPC_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic p_edge = 1'b0;
    logic n_edge = 1'b0;
    logic short_press, long_press, double_click, repeat_tick, busy;

    int checks = 0;
    int errors = 0;

    button_press_classifier #(
        .LONG_TICKS  (LT),
        .DCLICK_TICKS(DT),
        .REPEAT_TICKS(RT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .p_edge      (p_edge),
        .n_edge      (n_edge),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .repeat_tick (repeat_tick),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Drive one sampled cycle; returns #1 after the edge so outputs show its effect.
    task automatic tick(input logic p, input logic n);
        @(negedge clk);
        p_edge = p;
        n_edge = n;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        p_edge  = 1'b0;
        n_edge  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Reference: a gesture phase plus timestamps of when it began; durations are elapsed time.
    localparam int G_NONE = 0, G_HELD = 1, G_LONGHELD = 2, G_RELEASED = 3, G_HELD2 = 4;
    int m_phase, m_since, m_rep_since, m_now;
    logic e_s, e_l, e_d, e_r, e_b;

    task automatic model_reset();
        m_phase = G_NONE; m_since = 0; m_rep_since = 0; m_now = 0;
    endtask

    task automatic model_step(input logic p, input logic n);
        int nxt;
        int held;
        bit pe, ne;
        pe = p && !n;
        ne = n && !p;
        held = m_now - m_since + 1;
        nxt = m_phase;
        e_s = 0; e_l = 0; e_d = 0; e_r = 0;
        case (m_phase)
            G_NONE:     if (pe) nxt = G_HELD;
            G_HELD:     if (ne) nxt = G_RELEASED;
                        else if (held == LT) begin nxt = G_LONGHELD; e_l = 1; end
            G_LONGHELD: if (ne) nxt = G_NONE;
                        else if (AR && (m_now - m_rep_since + 1) == RT) begin
                            e_r = 1; m_rep_since = m_now + 1;
                        end
            G_RELEASED: if (pe) nxt = G_HELD2;
                        else if (held == DT) begin nxt = G_NONE; e_s = 1; end
            G_HELD2:    if (ne) begin nxt = G_NONE; e_d = 1; end
                        else if (held == LT) begin nxt = G_LONGHELD; e_d = 1; end
            default:    nxt = G_NONE;
        endcase
        if (nxt != m_phase) begin
            m_phase = nxt; m_since = m_now + 1; m_rep_since = m_now + 1;
        end
        e_b = (m_phase != G_NONE);
        m_now++;
    endtask

    typedef struct {
        int tp1, tn1, tp2, tn2, tb, t_end;
        int e_s, e_l, e_d, r_f, r_l, b_lo, b_hi;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int rf_b, rl_b, rf_d, rl_d;
        rf_b = AR ? 121 : -1; rl_b = AR ? 281 : -1;
        rf_d = AR ? 151 : -1; rl_d = AR ? 191 : -1;
        //         tp1 tn1  tp2 tn2 tb  end  short long dbl  rep_f rep_l busy_lo busy_hi
        vecs[0] = '{0,  30,  -1, -1, -1, 100, 71,  -1,  -1,  -1,   -1,   1,  70};
        vecs[1] = '{0,  300, -1, -1, -1, 320, -1,  101, -1,  rf_b, rl_b, 1,  300};
        vecs[2] = '{0,  10,  30, 40, -1, 80,  -1,  -1,  41,  -1,   -1,   1,  40};
        vecs[3] = '{0,  10,  30, 200,-1, 220, -1,  -1,  131, rf_d, rl_d, 1,  200};
        vecs[4] = '{0,  10,  50, 60, -1, 100, -1,  -1,  61,  -1,   -1,   1,  60};
        vecs[5] = '{0,  100, -1, -1, -1, 160, 141, -1,  -1,  -1,   -1,   1,  140};
        vecs[6] = '{0,  10,  -1, 50, -1, 80,  51,  -1,  -1,  -1,   -1,   1,  50};
        vecs[7] = '{-1, 3,   -1, -1, 5,  60,  -1,  -1,  -1,  -1,   -1,  -1,  -2};
        vecs[8] = '{0,  30,  -1, -1, 20, 100, 71,  -1,  -1,  -1,   -1,   1,  70};

        // Reset state, then a long quiet period.
        #1;
        chk("rst_short", short_press, 1'b0);
        chk("rst_long", long_press, 1'b0);
        chk("rst_dbl", double_click, 1'b0);
        chk("rst_rep", repeat_tick, 1'b0);
        chk("rst_busy", busy, 1'b0);
        do_reset();
        for (int c = 0; c < 200; c++) begin
            tick(1'b0, 1'b0);
            chk("idle_any", short_press | long_press | double_click | repeat_tick | busy, 1'b0);
        end

        for (int v = 0; v < 9; v++) begin
            do_reset();
            for (int c = 0; c <= vecs[v].t_end; c++) begin
                int k;
                logic p, n, er;
                p = (c == vecs[v].tp1) || (c == vecs[v].tp2) || (c == vecs[v].tb);
                n = (c == vecs[v].tn1) || (c == vecs[v].tn2) || (c == vecs[v].tb);
                tick(p, n);
                k = c + 1;
                er = (vecs[v].r_f >= 0) && (k >= vecs[v].r_f) && (k <= vecs[v].r_l)
                     && ((k - vecs[v].r_f) % RT == 0);
                chk($sformatf("tbl%0d_short", v), short_press, k == vecs[v].e_s);
                chk($sformatf("tbl%0d_long", v), long_press, k == vecs[v].e_l);
                chk($sformatf("tbl%0d_dbl", v), double_click, k == vecs[v].e_d);
                chk($sformatf("tbl%0d_rep", v), repeat_tick, er);
                chk($sformatf("tbl%0d_busy", v), busy, (k >= vecs[v].b_lo) && (k <= vecs[v].b_hi));
            end
        end

        // Reset in the middle of a press discards the gesture.
        do_reset();
        tick(1'b1, 1'b0);
        for (int c = 1; c < 50; c++) tick(1'b0, 1'b0);
        chk("pre_rst_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_pulses", short_press | long_press | double_click | repeat_tick, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 150; c++) begin
            tick(1'b0, 1'b0);
            chk("post_rst_quiet", short_press | long_press | double_click | repeat_tick | busy, 1'b0);
        end
        for (int c = 0; c <= 80; c++) begin
            tick(c == 0, c == 30);
            chk("fresh_short", short_press, (c + 1) == 71);
            chk("fresh_other", long_press | double_click, 1'b0);
        end

        // Randomized run with bursty and sparse edge densities.
        do_reset();
        model_reset();
        for (int seg = 0; seg < 20; seg++) begin
            int dens;
            case ($urandom_range(0, 2))
                0: dens = 2;
                1: dens = 10;
                default: dens = 40;
            endcase
            for (int c = 0; c < 300; c++) begin
                int r;
                logic p, n;
                r = $urandom_range(0, 999);
                p = (r < dens) || (r == 999);
                n = (r >= dens && r < 2 * dens) || (r == 999);
                tick(p, n);
                model_step(p, n);
                chk("rnd_short", short_press, e_s);
                chk("rnd_long", long_press, e_l);
                chk("rnd_dbl", double_click, e_d);
                chk("rnd_rep", repeat_tick, e_r);
                chk("rnd_busy", busy, e_b);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
